// File: rtl/pc_seq.sv
// Program-counter sequencer with relative/absolute branches and a circular
// return-address stack that overwrites its oldest entry on overflow.
module pc_seq #(
  parameter int              WIDTH     = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] INC       = WIDTH'(1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [2:0]                     op,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               q,
  output logic                           taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ovf,
  output logic                           unf
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptrInc;
  logic [PW-1:0]    ptrDec;
  logic [WIDTH-1:0] seqPc;
  logic [WIDTH-1:0] nextQ;
  logic             nextTaken;
  logic             doPush;
  logic             doPop;
  logic             setUnf;

  // ptr always names the slot the next push writes; the top lives one below it
  assign ptrInc = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign ptrDec = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
  assign seqPc  = q + INC;

  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  always_comb begin
    nextQ     = seqPc;
    nextTaken = 1'b0;
    doPush    = 1'b0;
    doPop     = 1'b0;
    setUnf    = 1'b0;
    case (op_e'(op))
      OP_BRANCH: begin
        nextQ     = q + target;
        nextTaken = 1'b1;
      end
      OP_JUMP: begin
        nextQ     = target;
        nextTaken = 1'b1;
      end
      OP_CALL: begin
        nextQ     = target;
        nextTaken = 1'b1;
        doPush    = 1'b1;
      end
      OP_RET: begin
        if (!ras_empty) begin
          nextQ     = stack[ptrDec];
          nextTaken = 1'b1;
          doPop     = 1'b1;
        end else begin
          setUnf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= RESET_VEC;
      taken     <= 1'b0;
      ras_count <= '0;
      ptr       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (en) begin
      q     <= nextQ;
      taken <= nextTaken;
      // a full stack keeps its count; the wrapped pointer overwrites the oldest
      if (doPush) begin
        ptr <= ptrInc;
        if (ras_full) begin
          ovf <= 1'b1;
        end else begin
          ras_count <= ras_count + 1'b1;
        end
      end
      if (doPop) begin
        ptr       <= ptrDec;
        ras_count <= ras_count - 1'b1;
      end
      if (setUnf) begin
        unf <= 1'b1;
      end
    end else begin
      taken <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && en && doPush) begin
      stack[ptr] <= seqPc;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue-based reference model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_pc_seq;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << WIDTH;

  localparam logic [2:0] NEXT   = 3'd0;
  localparam logic [2:0] BRANCH = 3'd1;
  localparam logic [2:0] JUMP   = 3'd2;
  localparam logic [2:0] CALL   = 3'd3;
  localparam logic [2:0] RET    = 3'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] target = '0;
  logic [WIDTH-1:0] q;
  logic             taken;
  logic [2:0]       ras_count;
  logic             ras_full;
  logic             ras_empty;
  logic             ovf;
  logic             unf;

  always #5 clk = ~clk;

  pc_seq #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(DEPTH),
    .RESET_VEC(16'h0000),
    .INC      (16'h0001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .op       (op),
    .target   (target),
    .q        (q),
    .taken    (taken),
    .ras_count(ras_count),
    .ras_full (ras_full),
    .ras_empty(ras_empty),
    .ovf      (ovf),
    .unf      (unf)
  );

  typedef struct {
    int q;
    bit taken;
    int count;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // reference model: PC as a plain integer, return stack as a bounded queue
  int mq = 0;
  int mStack[$];
  bit mTaken = 0;
  bit mOvf = 0;
  bit mUnf = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit e, input logic [2:0] o, input logic [WIDTH-1:0] t);
    if (r) begin
      mq = 0;
      mStack.delete();
      mOvf = 0;
      mUnf = 0;
      mTaken = 0;
    end else if (!e) begin
      mTaken = 0;
    end else begin
      mTaken = 0;
      case (o)
        BRANCH: begin
          mq = (mq + int'($signed(t)) + MOD) % MOD;
          mTaken = 1;
        end
        JUMP: begin
          mq = int'(t);
          mTaken = 1;
        end
        CALL: begin
          mStack.push_back((mq + 1) % MOD);
          if (mStack.size() > DEPTH) begin
            void'(mStack.pop_front());
            mOvf = 1;
          end
          mq = int'(t);
          mTaken = 1;
        end
        RET: begin
          if (mStack.size() > 0) begin
            mq = mStack.pop_back();
            mTaken = 1;
          end else begin
            mq = (mq + 1) % MOD;
            mUnf = 1;
          end
        end
        default: mq = (mq + 1) % MOD;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [2:0] o, input logic [WIDTH-1:0] t);
    exp_t x;
    @(negedge clk);
    #1;
    reset  = r;
    en     = e;
    op     = o;
    target = t;
    @(posedge clk);
    modelStep(r, e, o, t);
    x.q     = mq;
    x.taken = mTaken;
    x.count = mStack.size();
    x.ovf   = mOvf;
    x.unf   = mUnf;
    expQ.push_back(x);
    #1;
  endtask

  // monitor: every cycle is an output beat, compared against the oldest prediction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("q", 32'(q), 32'(e.q));
      checkOutput("taken", 32'(taken), 32'(e.taken));
      checkOutput("ras_count", 32'(ras_count), 32'(e.count));
      checkOutput("ras_full", 32'(ras_full), 32'(e.count == DEPTH));
      checkOutput("ras_empty", 32'(ras_empty), 32'(e.count == 0));
      checkOutput("ovf", 32'(ovf), 32'(e.ovf));
      checkOutput("unf", 32'(unf), 32'(e.unf));
    end
  end

  initial begin
    // reset and sequential run
    applyStimulus(1, 1, CALL, 16'h1234);
    checkOutput("reset q", 32'(q), 32'h0);
    checkOutput("reset count", 32'(ras_count), 32'h0);
    applyStimulus(0, 1, NEXT, 16'h0);
    checkOutput("next1", 32'(q), 32'h1);
    applyStimulus(0, 1, NEXT, 16'h0);
    checkOutput("next2", 32'(q), 32'h2);
    applyStimulus(0, 1, NEXT, 16'h0);
    checkOutput("next3", 32'(q), 32'h3);
    checkOutput("next taken", 32'(taken), 32'h0);

    // relative branch backwards, then wrap-around
    applyStimulus(0, 1, JUMP, 16'h0010);
    applyStimulus(0, 1, BRANCH, 16'hFFFC);
    checkOutput("branch q", 32'(q), 32'h000C);
    checkOutput("branch taken", 32'(taken), 32'h1);
    applyStimulus(0, 1, JUMP, 16'hFFFF);
    checkOutput("jump q", 32'(q), 32'hFFFF);
    applyStimulus(0, 1, NEXT, 16'h0);
    checkOutput("wrap q", 32'(q), 32'h0000);
    checkOutput("wrap taken", 32'(taken), 32'h0);

    // nested call/return
    applyStimulus(0, 1, JUMP, 16'h0100);
    applyStimulus(0, 1, CALL, 16'h0200);
    checkOutput("call1 q", 32'(q), 32'h0200);
    applyStimulus(0, 1, CALL, 16'h0300);
    checkOutput("call2 count", 32'(ras_count), 32'h2);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("ret1 q", 32'(q), 32'h0201);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("ret2 q", 32'(q), 32'h0101);
    checkOutput("ret2 count", 32'(ras_count), 32'h0);

    // overflow: five calls into a four-deep stack, then drain past empty
    applyStimulus(1, 0, NEXT, 16'h0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, CALL, 16'(i * 16));
    checkOutput("ovf set", 32'(ovf), 32'h1);
    checkOutput("ovf count", 32'(ras_count), 32'h4);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("ovf ret1", 32'(q), 32'h0041);
    applyStimulus(0, 1, RET, 16'h0);
    applyStimulus(0, 1, RET, 16'h0);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("ovf ret4", 32'(q), 32'h0011);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("unf q", 32'(q), 32'h0012);
    checkOutput("unf set", 32'(unf), 32'h1);
    checkOutput("unf taken", 32'(taken), 32'h0);

    // hold with en low, then reset while held
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, CALL, 16'h0500);
    checkOutput("hold q", 32'(q), 32'h0012);
    applyStimulus(1, 0, NEXT, 16'h0);
    checkOutput("held reset unf", 32'(unf), 32'h0);
    checkOutput("held reset ovf", 32'(ovf), 32'h0);

    // reset between call and return discards the return address
    applyStimulus(0, 1, CALL, 16'h0400);
    applyStimulus(1, 1, NEXT, 16'h0);
    applyStimulus(0, 1, RET, 16'h0);
    checkOutput("post-reset ret unf", 32'(unf), 32'h1);
    checkOutput("post-reset ret q", 32'(q), 32'h0001);

    // randomized traffic with occasional resets and stalls
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) != 0,
                    3'($urandom_range(0, 7)),
                    16'($urandom));
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
